// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package bcd2bin_seq_pkg;

  // Controller states; encodings are fixed so waveforms stay readable across builds
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Largest legal BCD digit
  localparam logic [3:0] BCD_MAX = 4'd9;
  // Correction applied to a digit after each right shift
  localparam logic [3:0] BCD_ADJ = 4'd3;
  // Digit value at or above which the correction applies
  localparam logic [3:0] BCD_THR = 4'd8;

endpackage

// File: rtl/bcd2bin_seq_digit_adj.sv
// Per-digit correction step of reverse double-dabble: d >= 8 -> d - 3.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj
  import bcd2bin_seq_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // 4-bit subtract, no carry out; only reached for 8..15 so it never wraps
  assign d_o = (d_i >= BCD_THR) ? (d_i - BCD_ADJ) : d_i;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Latency: done pulses W_BIN+1 cycles after the accepted start (11 for defaults).
// Backpressure: start only sampled in IDLE/DONE; ignored while busy, no queueing.
// Optional BCD_CHECK_EN: reject captured digits > 9 with err and a zero result.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int N_DIG = 3,
  parameter int W_BIN = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*N_DIG-1:0] bcd,
  output logic [W_BIN-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(W_BIN + 1);
  localparam int WB = 4 * N_DIG;
  localparam logic [CW-1:0] CNT_LAST = CW'(W_BIN - 1);

  state_e            state_q;
  logic [WB-1:0]     sr_bcd_q;
  logic [W_BIN-1:0]  sr_bin_q;
  logic [CW-1:0]     cnt_q;
  logic [W_BIN-1:0]  bin_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [WB+W_BIN-1:0] cat_sh;
  logic [WB-1:0]       sh_bcd;
  logic [WB-1:0]       adj_bcd;
  logic [W_BIN-1:0]    sh_bin;
  logic                start_bad;

  // One right shift of the combined register: digit LSBs ripple into the next lower digit,
  // the lowest digit's LSB lands in the binary MSB
  assign cat_sh = {sr_bcd_q, sr_bin_q} >> 1;
  assign sh_bcd = cat_sh[WB+W_BIN-1:W_BIN];
  assign sh_bin = cat_sh[W_BIN-1:0];

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sh_bcd[4*g +: 4]),
      .d_o (adj_bcd[4*g +: 4])
    );
  end

`ifdef BCD_CHECK_EN
  logic bcd_bad;

  // Flag any nibble outside 0..9 on the incoming digits
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd[4*i +: 4] > BCD_MAX) bcd_bad = 1'b1;
    end
  end

  assign start_bad = bcd_bad;
`else
  // Without checking, invalid nibbles are simply converted as-is
  assign start_bad = 1'b0;
`endif

  // Controller, shift datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_bcd_q <= '0;
      sr_bin_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sr_bcd_q <= bcd;
            sr_bin_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            err_q    <= start_bad;
            state_q  <= S_SHIFT;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (err_q) begin
            // Rejected input: skip the shifting and report a zero result straight away
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sr_bcd_q <= adj_bcd;
            sr_bin_q <= sh_bin;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              bin_q   <= sh_bin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
